// File: rtl/position_delay_line.sv
// Position delay line: clamps packed coordinates, captures them (optionally
// frame-locked), and delays them through DEPTH freezable stages.
module position_delay_line #(
  parameter int WIDTH = 12,
  parameter int CHANNELS = 2,
  parameter int DEPTH = 2,
  parameter int FRAME_LOCK = 1,
  parameter logic [WIDTH-1:0] MAX_VAL = 12'hFFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] pos_in,
  input  logic                      in_valid,
  input  logic                      frame_start,
  input  logic                      freeze,
  output logic [CHANNELS*WIDTH-1:0] pos_out,
  output logic                      out_valid
);

  localparam int PW = CHANNELS * WIDTH;

  logic [PW-1:0]    stg [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    pend;
  logic             pend_flag;
  logic [PW-1:0]    clamped;
  logic [PW-1:0]    cap_d;
  logic             cap_ld;
  logic             fs_go;

  always_comb begin
    clamped = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (pos_in[k*WIDTH +: WIDTH] > MAX_VAL)
        clamped[k*WIDTH +: WIDTH] = MAX_VAL;
      else
        clamped[k*WIDTH +: WIDTH] = pos_in[k*WIDTH +: WIDTH];
    end
  end

  assign fs_go = frame_start && !freeze;

  // Same-cycle sample bypasses the pending register
  always_comb begin
    cap_ld = 1'b0;
    cap_d  = clamped;
    if (FRAME_LOCK == 0) begin
      cap_ld = in_valid && !freeze;
    end else if (fs_go) begin
      if (in_valid) begin
        cap_ld = 1'b1;
      end else if (pend_flag) begin
        cap_ld = 1'b1;
        cap_d  = pend;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend      <= '0;
      pend_flag <= 1'b0;
    end else if (FRAME_LOCK != 0) begin
      if (in_valid)
        pend <= clamped;
      if (fs_go && (in_valid || pend_flag))
        pend_flag <= 1'b0;
      else if (in_valid)
        pend_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        stg[i] <= '0;
      vld <= '0;
    end else begin
      if (cap_ld) begin
        stg[0] <= cap_d;
        vld[0] <= 1'b1;
      end
      if (!freeze) begin
        for (int i = 1; i < DEPTH; i++) begin
          stg[i] <= stg[i-1];
          vld[i] <= vld[i-1];
        end
      end
    end
  end

  assign pos_out   = stg[DEPTH-1];
  assign out_valid = vld[DEPTH-1];

endmodule

// File: tb/tb_position_delay_line.sv
// Directed bench for position_delay_line across three parameter sets.
module tb_position_delay_line;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] pos_in = '0;
  logic        in_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic        freeze = 1'b0;
  logic [23:0] o0, o1, o2;
  logic        v0, v1, v2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // dut0: free-running capture, clamp 1023
  position_delay_line #(.WIDTH(12), .CHANNELS(2), .DEPTH(2),
    .FRAME_LOCK(0), .MAX_VAL(12'd1023)) dut0 (
    .clk(clk), .rst(rst), .pos_in(pos_in), .in_valid(in_valid),
    .frame_start(frame_start), .freeze(freeze),
    .pos_out(o0), .out_valid(v0));

  // dut1: frame-locked, three stages
  position_delay_line #(.WIDTH(12), .CHANNELS(2), .DEPTH(3),
    .FRAME_LOCK(1), .MAX_VAL(12'hFFF)) dut1 (
    .clk(clk), .rst(rst), .pos_in(pos_in), .in_valid(in_valid),
    .frame_start(frame_start), .freeze(freeze),
    .pos_out(o1), .out_valid(v1));

  // dut2: single stage, free-running
  position_delay_line #(.WIDTH(12), .CHANNELS(2), .DEPTH(1),
    .FRAME_LOCK(0), .MAX_VAL(12'hFFF)) dut2 (
    .clk(clk), .rst(rst), .pos_in(pos_in), .in_valid(in_valid),
    .frame_start(frame_start), .freeze(freeze),
    .pos_out(o2), .out_valid(v2));

  function automatic logic [23:0] pk(input int x, input int y);
    logic [11:0] xs, ys;
    xs = x[11:0];
    ys = y[11:0];
    return {ys, xs};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    pos_in = '0;
    in_valid = 1'b0;
    frame_start = 1'b0;
    freeze = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pos_in = pk(5, 6);
    in_valid = 1'b1;
    frame_start = 1'b1;
    tick();
    tick();
    checks++;
    if ({v0, o0} !== 25'd0) begin
      errors++;
      $display("FAIL reset_dut0: got %b/%h want 0/000000", v0, o0);
    end
    checks++;
    if ({v1, o1} !== 25'd0) begin
      errors++;
      $display("FAIL reset_dut1: got %b/%h want 0/000000", v1, o1);
    end
    checks++;
    if ({v2, o2} !== 25'd0) begin
      errors++;
      $display("FAIL reset_dut2: got %b/%h want 0/000000", v2, o2);
    end
    idle();
    rst = 1'b1;
  endtask

  task automatic test_free_run();
    do_reset();
    pos_in = pk(100, 50);
    in_valid = 1'b1;
    tick();
    idle();
    checks++;
    if ({v0, o0} !== {1'b0, 24'd0}) begin
      errors++;
      $display("FAIL fr_early: got %b/%h want 0/000000", v0, o0);
    end
    checks++;
    if ({v2, o2} !== {1'b1, pk(100, 50)}) begin
      errors++;
      $display("FAIL fr_depth1: got %b/%h want 1/%h", v2, o2, pk(100, 50));
    end
    tick();
    checks++;
    if ({v0, o0} !== {1'b1, pk(100, 50)}) begin
      errors++;
      $display("FAIL fr_out: got %b/%h want 1/%h", v0, o0, pk(100, 50));
    end
    pos_in = pk(5, 5);
    in_valid = 1'b1;
    freeze = 1'b1;
    tick();
    tick();
    idle();
    tick();
    checks++;
    if (o0 !== pk(100, 50)) begin
      errors++;
      $display("FAIL fr_freeze: got %h want %h", o0, pk(100, 50));
    end
  endtask

  task automatic test_clamp();
    do_reset();
    pos_in = pk(2000, 500);
    in_valid = 1'b1;
    tick();
    pos_in = pk(1023, 1024);
    tick();
    checks++;
    if (o0 !== pk(1023, 500)) begin
      errors++;
      $display("FAIL clamp_x: got %h want %h", o0, pk(1023, 500));
    end
    pos_in = pk(4095, 2000);
    tick();
    idle();
    checks++;
    if (o0 !== pk(1023, 1023)) begin
      errors++;
      $display("FAIL clamp_edge: got %h want %h", o0, pk(1023, 1023));
    end
    checks++;
    if (o2 !== pk(4095, 2000)) begin
      errors++;
      $display("FAIL clamp_max: got %h want %h", o2, pk(4095, 2000));
    end
  endtask

  task automatic test_frame_lock();
    do_reset();
    frame_start = 1'b1;
    tick();
    idle();
    tick();
    tick();
    tick();
    checks++;
    if (v1 !== 1'b0) begin
      errors++;
      $display("FAIL fl_nopend: got %b want 0", v1);
    end
    pos_in = pk(300, 0);
    in_valid = 1'b1;
    tick();
    idle();
    tick();
    tick();
    pos_in = pk(310, 0);
    in_valid = 1'b1;
    tick();
    idle();
    tick();
    checks++;
    if ({v1, o1} !== 25'd0) begin
      errors++;
      $display("FAIL fl_wait: got %b/%h want 0/000000", v1, o1);
    end
    frame_start = 1'b1;
    tick();
    idle();
    tick();
    checks++;
    if (v1 !== 1'b0) begin
      errors++;
      $display("FAIL fl_lat: got %b want 0", v1);
    end
    tick();
    checks++;
    if ({v1, o1} !== {1'b1, pk(310, 0)}) begin
      errors++;
      $display("FAIL fl_out: got %b/%h want 1/%h", v1, o1, pk(310, 0));
    end
  endtask

  task automatic test_bypass();
    pos_in = pk(77, 7);
    in_valid = 1'b1;
    frame_start = 1'b1;
    tick();
    idle();
    tick();
    tick();
    checks++;
    if (o1 !== pk(77, 7)) begin
      errors++;
      $display("FAIL byp_out: got %h want %h", o1, pk(77, 7));
    end
    frame_start = 1'b1;
    tick();
    idle();
    tick();
    tick();
    tick();
    checks++;
    if ({v1, o1} !== {1'b1, pk(77, 7)}) begin
      errors++;
      $display("FAIL byp_hold: got %b/%h want 1/%h", v1, o1, pk(77, 7));
    end
  endtask

  task automatic test_freeze();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      pos_in = pk(i, 0);
      in_valid = 1'b1;
      frame_start = 1'b1;
      tick();
    end
    idle();
    checks++;
    if ({v1, o1} !== {1'b1, pk(1, 0)}) begin
      errors++;
      $display("FAIL frz_fill: got %b/%h want 1/%h", v1, o1, pk(1, 0));
    end
    freeze = 1'b1;
    pos_in = pk(9, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    checks++;
    if ({v1, o1} !== {1'b1, pk(1, 0)}) begin
      errors++;
      $display("FAIL frz_hold: got %b/%h want 1/%h", v1, o1, pk(1, 0));
    end
    idle();
    tick();
    checks++;
    if (o1 !== pk(2, 0)) begin
      errors++;
      $display("FAIL frz_resume: got %h want %h", o1, pk(2, 0));
    end
    tick();
    checks++;
    if (o1 !== pk(3, 0)) begin
      errors++;
      $display("FAIL frz_shift: got %h want %h", o1, pk(3, 0));
    end
    frame_start = 1'b1;
    tick();
    idle();
    tick();
    tick();
    checks++;
    if (o1 !== pk(9, 0)) begin
      errors++;
      $display("FAIL frz_pend: got %h want %h", o1, pk(9, 0));
    end
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({v0, o0, v1, o1} !== 50'd0) begin
      errors++;
      $display("FAIL arst: got %b/%h %b/%h want zeros", v0, o0, v1, o1);
    end
    rst = 1'b1;
    @(negedge clk);
    pos_in = pk(11, 22);
    in_valid = 1'b1;
    tick();
    idle();
    checks++;
    if (v0 !== 1'b0) begin
      errors++;
      $display("FAIL arst_lat: got %b want 0", v0);
    end
    tick();
    checks++;
    if ({v0, o0} !== {1'b1, pk(11, 22)}) begin
      errors++;
      $display("FAIL arst_refill: got %b/%h want 1/%h", v0, o0, pk(11, 22));
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_free_run();
    test_clamp();
    test_frame_lock();
    test_bypass();
    test_freeze();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/position_delay_line.md
POSITION_DELAY_LINE -- requirements
Module: position_delay_line

Interface
REQ-001 SHALL provide parameter WIDTH, default 12, bit width of one coordinate.
REQ-002 SHALL provide parameter CHANNELS, default 2, number of coordinates carried (ch0 = x, ch1 = y).
REQ-003 SHALL provide parameter DEPTH, default 2, total stages from capture to output; legal range 1..16.
REQ-004 SHALL provide parameter FRAME_LOCK, default 1; 1 = capture only on frame_start, 0 = capture on every in_valid.
REQ-005 SHALL provide parameter MAX_VAL, default 12'hFFF, per-coordinate upper clamp, applied to all channels.
REQ-006 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port pos_in  input  CHANNELS*WIDTH  packed coordinates; channel k at bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port in_valid  input  1  pos_in is a new sample this cycle.
REQ-010 SHALL have port frame_start  input  1  one-cycle pulse at start of vertical blank.
REQ-011 SHALL have port freeze  input  1  hold capture and delay stages.
REQ-012 SHALL have port pos_out  output  CHANNELS*WIDTH  delayed coordinates, same packing as pos_in.
REQ-013 SHALL have port out_valid  output  1  pos_out carries a captured sample.

Function
REQ-014 SHALL clamp each channel independently to MAX_VAL when loading capture or pending: v > MAX_VAL -> MAX_VAL, else v.
REQ-015 FRAME_LOCK=0: capture stage SHALL load clamped pos_in in any cycle with in_valid=1 and freeze=0; otherwise hold.
REQ-016 FRAME_LOCK=1: pending register SHALL load clamped pos_in and set pend_flag on in_valid=1, regardless of freeze.
REQ-017 FRAME_LOCK=1: on frame_start=1, freeze=0, pend_flag=1, capture SHALL load pending and pend_flag SHALL clear.
REQ-018 FRAME_LOCK=1, frame_start=1 and in_valid=1 same cycle, freeze=0: capture SHALL load clamped pos_in directly (bypass); pending also loads it; pend_flag SHALL clear.
REQ-019 FRAME_LOCK=1, frame_start=1 with pend_flag=0 and in_valid=0: capture SHALL hold its value.
REQ-020 FRAME_LOCK=1, frame_start=1 while freeze=1: capture SHALL hold; pend_flag SHALL remain set (sample transfers on a later frame_start).
REQ-021 Capture SHALL be stage 1; stages 2..DEPTH SHALL shift one position per cycle when freeze=0 and hold when freeze=1.
REQ-022 pos_out SHALL equal stage DEPTH; DEPTH=1 -> pos_out is the capture register.
REQ-023 Latency: a capture load in cycle N SHALL appear on pos_out after rising edge N+DEPTH-1 (visible in cycle N+DEPTH), with no freeze in between.
REQ-024 Each stage SHALL carry a valid bit; capture valid SHALL set on first load and stay set until reset; valid bits SHALL shift with data.
REQ-025 out_valid SHALL equal the stage-DEPTH valid bit.
REQ-026 Output SHALL be glitch-free registered; no combinational path from inputs to pos_out or out_valid.

Reset
REQ-027 rst=0 SHALL immediately clear all stages, pending, pend_flag and valid bits; pos_out=0, out_valid=0.
REQ-028 Reset asserted mid-pipeline SHALL discard all in-flight samples; after release first capture follows REQ-015..REQ-018 normally.
REQ-029 Inputs SHALL be ignored while rst=0; first register update occurs on the first rising edge with rst=1.

Verification
REQ-030 FRAME_LOCK=0, DEPTH=2: in_valid with pos_in x=100, y=50 at cycle 5 -> pos_out x=100, y=50, out_valid=1 from cycle 7; 0/0 before.
REQ-031 FRAME_LOCK=1: in_valid x=300 at cycle 3, x=310 at cycle 8, frame_start at cycle 10 -> capture=310 at cycle 11; 300 never reaches output.
REQ-032 FRAME_LOCK=1: frame_start and in_valid x=77 same cycle -> capture=77 next cycle, pend_flag=0; frame_start with no pending -> output unchanged.
REQ-033 Clamp, MAX_VAL=1023: pos_in x=2000, y=500 -> pos_out x=1023, y=500.
REQ-034 freeze=1 for 4 cycles mid-shift, DEPTH=3 -> all stages and out_valid hold; shifting resumes the cycle after freeze drops; frame_start during freeze keeps pend_flag=1.
REQ-035 rst=0 pulsed asynchronously between clock edges with pipeline full -> pos_out=0, out_valid=0 immediately; refill latency matches REQ-023.
